// File: rtl/mdu_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO and raises busy for a fixed
// number of cycles per operation. Optional MADD/MSUB ops are built with `define MDU_MADD_EN.
`timescale 1ns/1ps

module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [63:0]        pend_reg, pend_next;
    logic               pend_wr_reg, pend_wr_next;
    logic [31:0]        hi_reg, hi_next;
    logic [31:0]        lo_reg, lo_next;

    // Multiplier: operands extended to 64 bits so the low 64 product bits are
    // correct for both signed and unsigned forms from one unsigned multiply.
    logic        mul_signed;
    logic [63:0] mul_a, mul_b, prod;

    assign mul_signed = (op != OP_MULTU);
    assign mul_a      = {{32{mul_signed & a[31]}}, a};
    assign mul_b      = {{32{mul_signed & b[31]}}, b};
    assign prod       = mul_a * mul_b;

    // Divider: one unsigned divider on magnitudes, signs restored afterwards.
    // This gives truncation toward zero, a dividend-signed remainder, and maps
    // 0x80000000 / -1 to quotient 0x80000000, remainder 0 without special casing.
    logic        div_signed, a_neg, b_neg, div_by_zero;
    logic [31:0] abs_a, abs_b, div_den, uq, ur, quot, rem;

    assign div_signed  = (op == OP_DIV);
    assign a_neg       = div_signed & a[31];
    assign b_neg       = div_signed & b[31];
    assign abs_a       = a_neg ? (32'd0 - a) : a;
    assign abs_b       = b_neg ? (32'd0 - b) : b;
    assign div_by_zero = (b == 32'd0);
    assign div_den     = div_by_zero ? 32'd1 : abs_b;
    assign uq          = abs_a / div_den;
    assign ur          = abs_a % div_den;
    assign quot        = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    assign rem         = a_neg ? (32'd0 - ur) : ur;

`ifdef MDU_MADD_EN
    // Accumulator uses HI/LO as they stand at the accepting edge.
    logic [63:0] acc_sum, acc_diff;

    assign acc_sum  = {hi_reg, lo_reg} + prod;
    assign acc_diff = {hi_reg, lo_reg} - prod;
`endif

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pend_next    = pend_reg;
        pend_wr_next = pend_wr_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            pend_next    = prod;
                            pend_wr_next = 1'b1;
                            cnt_next     = CNT_W'(MULT_CYCLES);
                            state_next   = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_next    = {rem, quot};
                            pend_wr_next = ~div_by_zero;
                            cnt_next     = CNT_W'(DIV_CYCLES);
                            state_next   = RUN;
                        end
                        OP_MTHI: hi_next = a;
                        OP_MTLO: lo_next = a;
`ifdef MDU_MADD_EN
                        OP_MADD: begin
                            pend_next    = acc_sum;
                            pend_wr_next = 1'b1;
                            cnt_next     = CNT_W'(MULT_CYCLES);
                            state_next   = RUN;
                        end
                        OP_MSUB: begin
                            pend_next    = acc_diff;
                            pend_wr_next = 1'b1;
                            cnt_next     = CNT_W'(MULT_CYCLES);
                            state_next   = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Last busy cycle: commit at this edge so HI/LO change as busy drops.
                if (cnt_reg <= CNT_W'(1)) begin
                    if (pend_wr_reg) begin
                        hi_next = pend_reg[63:32];
                        lo_next = pend_reg[31:0];
                    end
                    pend_wr_next = 1'b0;
                    cnt_next     = '0;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            pend_reg    <= '0;
            pend_wr_reg <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pend_reg    <= pend_next;
            pend_wr_reg <= pend_wr_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
        end
    end

    assign busy = (state_reg == RUN);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit: latency, HI/LO results, divide by
// zero, ignored starts, reserved ops (or MADD/MSUB) and asynchronous reset.
`timescale 1ns/1ps

module tb_mdu_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_fail;

    mdu_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a one-cycle start; returns at the negedge after the accepting edge.
    task automatic pulse(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count busy cycles, bounded so a stuck DUT still reaches the summary.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Start an op, check HI/LO hold their old value in the first busy cycle,
    // then check the busy length and the committed result.
    task automatic run_op(input string name, input logic [2:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input int exp_cycles,
                          input logic [31:0] old_hi, input logic [31:0] old_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        pulse(o, x, y);
        check({name, "_hi_hold"}, hi, old_hi);
        check({name, "_lo_hold"}, lo, old_lo);
        count_busy(n);
        check({name, "_cycles"}, n, exp_cycles);
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
        $display("txn %s a=0x%08h b=0x%08h busy=%0d hi=0x%08h lo=0x%08h", name, x, y, n, hi, lo);
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        start    = 1'b0;
        op       = 3'd0;
        a        = '0;
        b        = '0;
        rst_n    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst_n = 1'b1;
        $display("txn reset busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);

        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5,
               32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_minmin", 3'd0, 32'h8000_0000, 32'h8000_0000, 5,
               32'hFFFF_FFFE, 32'h0000_0001, 32'h4000_0000, 32'h0000_0000);
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10,
               32'h4000_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0000, 32'h8000_0000);
        run_op("divu", 3'd3, 32'd100, 32'd7, 10,
               32'h0, 32'h8000_0000, 32'd2, 32'd14);
        run_op("div_neg_divisor", 3'd2, 32'd7, 32'hFFFF_FFFE, 10,
               32'd2, 32'd14, 32'd1, 32'hFFFF_FFFD);

        pulse(3'd4, 32'h0000_1234, 32'h0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_hi", hi, 32'h0000_1234);
        pulse(3'd5, 32'h0000_5678, 32'h0);
        check("mtlo_lo", lo, 32'h0000_5678);
        check("mtlo_hi", hi, 32'h0000_1234);
        $display("txn mthi/mtlo hi=0x%08h lo=0x%08h", hi, lo);

        // divu by zero with stray starts injected while busy
        pulse(3'd3, 32'd99, 32'd0);
        n = 0;
        while (busy && n < 100) begin
            start = (n == 2) || (n == 5);
            op    = (n == 2) ? 3'd0 : 3'd4;
            a     = 32'hDEAD_BEEF;
            b     = 32'd3;
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check("div0_cycles", n, 10);
        check("div0_hi", hi, 32'h0000_1234);
        check("div0_lo", lo, 32'h0000_5678);
        @(negedge clk);
        check("div0_no_restart", {31'd0, busy}, 32'd0);
        $display("txn divu_by_zero busy=%0d hi=0x%08h lo=0x%08h", n, hi, lo);

`ifdef MDU_MADD_EN
        pulse(3'd4, 32'd0, 32'd0);
        pulse(3'd5, 32'd10, 32'd0);
        run_op("madd", 3'd6, 32'd3, 32'd4, 5,
               32'd0, 32'd10, 32'd0, 32'd22);
        run_op("msub", 3'd7, 32'd5, 32'd5, 5,
               32'd0, 32'd22, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        pulse(3'd4, 32'h0000_1234, 32'h0);
        pulse(3'd5, 32'h0000_5678, 32'h0);
`else
        pulse(3'd6, 32'd3, 32'd4);
        check("rsv6_busy", {31'd0, busy}, 32'd0);
        pulse(3'd7, 32'd5, 32'd5);
        check("rsv7_busy", {31'd0, busy}, 32'd0);
        check("rsv_hi", hi, 32'h0000_1234);
        check("rsv_lo", lo, 32'h0000_5678);
        $display("txn reserved ops busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);
`endif

        // Asynchronous reset in busy cycle 4 of a divide
        pulse(3'd2, 32'd100, 32'd3);
        repeat (3) @(negedge clk);
        check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        $display("txn reset_mid_op busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_mid_no_commit_hi", hi, 32'd0);
        check("rst_mid_no_commit_lo", lo, 32'd0);

        run_op("multu_after_rst", 3'd1, 32'd6, 32'd7, 5,
               32'd0, 32'd0, 32'd0, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the EX stage of the P6 pipeline, in parallel with the integer ALU.
- Consumes the same forwarded rs/rt operands as the ALU.
- Owns the architectural HI/LO registers.
- Provides a multi-cycle busy interlock so the hazard unit stalls dependent MDU instructions in ID.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy duration for div/divu (must be >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse: EX holds an MDU instruction.
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved (MADD/MSUB when enabled).
- a  input  32  rs operand, already forwarded.
- b  input  32  rt operand, already forwarded.
- busy  output  1  operation in flight.
- hi  output  32  architectural HI, read by mfhi.
- lo  output  32  architectural LO, read by mflo.

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE, busy=0, hi=0, lo=0, counter=0, pending result cleared. Reset mid-operation discards the in-flight result.
- States: IDLE and RUN.
- IDLE + start, op mult/multu/div/divu:
  - Compute the result from a/b at that edge into a 64-bit pending register.
  - Load counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
  - busy=1 from the following cycle.
- RUN: counter decrements every cycle. When the counter reaches 1:
  - Commit pending to {hi,lo} at that edge.
  - Return to IDLE; busy=0 in the next cycle.
- Timing: a start sampled at edge t gives busy high for cycles t..t+N-1 (N edges after t). The new hi/lo are visible at the same cycle busy falls.
- mult: {hi,lo} = signed(a) * signed(b), 64-bit. multu: unsigned.
- div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - a=0x80000000, b=0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient and remainder.
- Divide by zero (b=0): the operation still runs DIV_CYCLES with busy asserted; hi/lo are left unchanged at commit.
- mthi/mtlo: write hi or lo with a at the next edge; no busy, single cycle. Accepted only in IDLE.
- start while busy=1: ignored, no state change. The hazard unit guarantees this never happens in legal flow; the bench checks that it is harmless.
- mfhi/mflo are combinational reads of hi/lo. During RUN they return the old values; the stall logic must hold mfhi/mflo while (busy | start).
- Reserved op with start: ignored.
- Outputs change only on a clock edge or on reset.

Optional Feature:
- MDU_MADD_EN defined:
  - op 6 = madd, op 7 = msub, signed.
  - {hi,lo} ± signed(a)*signed(b); uses MULT_CYCLES.
  - The accumulation uses the {hi,lo} value captured at start; the 64-bit result wraps modulo 2^64.
- Not defined: ops 6/7 are reserved and ignored; no accumulator adder is synthesized.

Test Plan:
- Reset, then start mult a=0xFFFFFFFE(-2), b=3 → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div a=0xFFFFFFF9(-7), b=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide by zero:
  - mthi 0x1234, then mtlo 0x5678, then divu b=0 → busy 10 cycles; hi=0x1234, lo=0x5678 unchanged.
  - Extra start pulses during busy leave the result and timing unaffected.
- Reset mid-operation: div started, rst_n low on busy cycle 4 → busy=0, hi=lo=0 immediately.
  - A following multu 6*7 gives lo=42, hi=0 after 5 cycles.
- MDU_MADD_EN defined: hi=0, lo=10; madd a=3, b=4 → lo=22. Then msub a=5, b=5 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
